// File: rtl/des_pipe_sched.sv
// des_pipe_sched: scheduler / flow controller for a fixed-latency pipelined DES datapath.
// Admits 64-bit blocks from a ready/valid source and issues them into the free-running
// pipeline. A {valid, tag} shift chain tracks each block through the pipeline at matched
// latency. Results land in an output FIFO. Admission is gated by credits, so the FIFO
// cannot overflow under downstream backpressure.
//
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   start, flush                   control pulses (IDLE->RUN, RUN->DRAIN)
//   busy, flush_done               status (not IDLE, DRAIN->IDLE pulse)
//   s_valid/s_ready/s_data/s_mode/s_tag    upstream block interface
//   pipe_in_valid/pipe_in_data/pipe_in_mode  issue to pipeline
//   pipe_out_data                  pipeline result, LATENCY cycles after issue
//   m_valid/m_ready/m_data/m_tag   downstream result interface (FIFO head)
//
// Optional feature macro DES_PIPE_SCHED_STATS_EN adds saturating counters
// stat_blocks (pops) and stat_stall (cycles with s_valid && !s_ready in RUN).
module des_pipe_sched #(
   parameter int unsigned LATENCY   = 17,
   parameter int unsigned OUT_DEPTH = 4,
   parameter int unsigned TAG_W     = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             flush,
   output logic             busy,
   output logic             flush_done,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [63:0]      s_data,
   input  logic             s_mode,
   input  logic [TAG_W-1:0] s_tag,
   output logic             pipe_in_valid,
   output logic [63:0]      pipe_in_data,
   output logic             pipe_in_mode,
   input  logic [63:0]      pipe_out_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [63:0]      m_data,
   output logic [TAG_W-1:0] m_tag
`ifdef DES_PIPE_SCHED_STATS_EN
   ,
   output logic [31:0]      stat_blocks,
   output logic [31:0]      stat_stall
`endif
);

   localparam int unsigned IFW = $clog2(LATENCY + 1);
   localparam int unsigned CW  = $clog2(OUT_DEPTH + 1);
   localparam int unsigned PW  = $clog2(OUT_DEPTH);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [IFW-1:0]   inflight_q, inflight_d;
   logic [CW-1:0]    count_q, count_d;
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [63:0]      mem_data_q [OUT_DEPTH];
   logic [TAG_W-1:0] mem_tag_q [OUT_DEPTH];
   logic [LATENCY-1:0] chain_v_q;
   logic [TAG_W-1:0] chain_tag_q [LATENCY];

   logic        accept, push, pop, drained;
   int unsigned used;

   // Every admitted block not yet popped holds one credit.
   assign used    = 32'(inflight_q) + 32'(count_q);
   assign s_ready = (state_q == RUN) && (used < OUT_DEPTH);
   assign accept  = s_valid && s_ready;

   assign pipe_in_valid = accept;
   assign pipe_in_data  = s_data;
   assign pipe_in_mode  = s_mode;

   assign push    = chain_v_q[LATENCY-1];
   assign m_valid = (count_q != '0);
   assign pop     = m_valid && m_ready;
   assign m_data  = mem_data_q[rd_ptr_q];
   assign m_tag   = mem_tag_q[rd_ptr_q];

   // inflight == 0 already excludes a push this cycle; !push kept for clarity.
   assign drained    = (inflight_q == '0) && (count_q == '0) && !push;
   assign busy       = (state_q != IDLE);
   assign flush_done = (state_q == DRAIN) && drained;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (flush) state_d = DRAIN;
         DRAIN:   if (drained) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      inflight_d = inflight_q;
      if (accept && !push) begin
         inflight_d = inflight_q + IFW'(1);
      end else if (push && !accept) begin
         inflight_d = inflight_q - IFW'(1);
      end
   end

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         inflight_q <= '0;
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         chain_v_q  <= '0;
         for (int i = 0; i < int'(LATENCY); i++) begin
            chain_tag_q[i] <= '0;
         end
         for (int i = 0; i < int'(OUT_DEPTH); i++) begin
            mem_data_q[i] <= '0;
            mem_tag_q[i]  <= '0;
         end
      end else begin
         state_q    <= state_d;
         inflight_q <= inflight_d;
         count_q    <= count_d;
         chain_v_q[0]   <= accept;
         chain_tag_q[0] <= s_tag;
         for (int i = 1; i < int'(LATENCY); i++) begin
            chain_v_q[i]   <= chain_v_q[i-1];
            chain_tag_q[i] <= chain_tag_q[i-1];
         end
         if (push) begin
            mem_data_q[wr_ptr_q] <= pipe_out_data;
            mem_tag_q[wr_ptr_q]  <= chain_tag_q[LATENCY-1];
            wr_ptr_q             <= wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
      end
   end

`ifdef DES_PIPE_SCHED_STATS_EN
   logic [31:0] stat_blocks_q, stat_stall_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stat_blocks_q <= '0;
         stat_stall_q  <= '0;
      end else begin
         if (pop && (stat_blocks_q != '1)) begin
            stat_blocks_q <= stat_blocks_q + 32'd1;
         end
         if ((state_q == RUN) && s_valid && !s_ready && (stat_stall_q != '1)) begin
            stat_stall_q <= stat_stall_q + 32'd1;
         end
      end
   end

   assign stat_blocks = stat_blocks_q;
   assign stat_stall  = stat_stall_q;
`endif

endmodule

// File: tb/tb_des_pipe_sched.sv
// Self-checking bench for des_pipe_sched. A transaction-level model (queue of admitted
// blocks with their arrival cycle) predicts s_ready, m_valid, head data/tag and flush_done.
module tb_des_pipe_sched;

   localparam int unsigned LATENCY   = 17;
   localparam int unsigned OUT_DEPTH = 4;
   localparam int unsigned TAG_W     = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             start, flush, busy, flush_done;
   logic             s_valid, s_ready, s_mode;
   logic [63:0]      s_data;
   logic [TAG_W-1:0] s_tag;
   logic             pipe_in_valid, pipe_in_mode;
   logic [63:0]      pipe_in_data, pipe_out_data;
   logic             m_valid, m_ready;
   logic [63:0]      m_data;
   logic [TAG_W-1:0] m_tag;

   des_pipe_sched #(
      .LATENCY(LATENCY), .OUT_DEPTH(OUT_DEPTH), .TAG_W(TAG_W)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .flush(flush), .busy(busy),
      .flush_done(flush_done), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .s_mode(s_mode), .s_tag(s_tag), .pipe_in_valid(pipe_in_valid),
      .pipe_in_data(pipe_in_data), .pipe_in_mode(pipe_in_mode),
      .pipe_out_data(pipe_out_data), .m_valid(m_valid), .m_ready(m_ready),
      .m_data(m_data), .m_tag(m_tag)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] xf(input logic [63:0] d);
      return {d[31:0], d[63:32]} ^ 64'hA5A5_5A5A_0F0F_F0F0;
   endfunction

   // Stand-in for the DES datapath: fixed LATENCY, never reset.
   logic [63:0] pipe_sr [LATENCY];
   always @(posedge clk) begin
      pipe_sr[0] <= xf(pipe_in_data);
      for (int i = 1; i < int'(LATENCY); i++) pipe_sr[i] <= pipe_sr[i-1];
   end
   assign pipe_out_data = pipe_sr[LATENCY-1];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int st       = 0;  // 0 idle, 1 run, 2 drain
   int n_acc    = 0;
   int n_done   = 0;
   int last_tag = -1;
   logic [63:0]      q_data [$];
   logic [TAG_W-1:0] q_tag [$];
   int               q_arr [$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at a negedge with inputs already driven; checks, updates model, advances a cycle.
   task automatic step();
      bit exp_rdy, exp_mv, exp_done, acc, pop;
      #1;
      exp_rdy  = (st == 1) && (q_tag.size() < OUT_DEPTH);
      exp_mv   = (q_tag.size() > 0) && (q_arr[0] <= cyc);
      exp_done = (st == 2) && (q_tag.size() == 0);
      acc      = s_valid && exp_rdy;
      chk("s_ready", s_ready, exp_rdy);
      chk("m_valid", m_valid, exp_mv);
      chk("pipe_in_valid", pipe_in_valid, acc);
      chk("busy", busy, st != 0);
      chk("flush_done", flush_done, exp_done);
      chk("fifo_full_push", dut.push && (int'(dut.count_q) == OUT_DEPTH), 0);
      if (acc) chk("pipe_in_data", pipe_in_data, s_data);
      if (exp_mv) begin
         chk("m_data", m_data, q_data[0]);
         chk("m_tag", m_tag, q_tag[0]);
      end
      pop = exp_mv && m_ready;
      if (pop) begin
         last_tag = int'(q_tag[0]);
         void'(q_data.pop_front());
         void'(q_tag.pop_front());
         void'(q_arr.pop_front());
      end
      if (acc) begin
         q_data.push_back(xf(s_data));
         q_tag.push_back(s_tag);
         q_arr.push_back(cyc + int'(LATENCY) + 1);
         n_acc++;
      end
      if (st == 0 && start) st = 1;
      else if (st == 1 && flush) st = 2;
      else if (exp_done) begin
         st = 0;
         n_done++;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic drain(input int max);
      int n;
      s_valid = 1'b0;
      m_ready = 1'b1;
      n = 0;
      while (q_tag.size() > 0 && n < max) begin
         step();
         n++;
      end
      if (q_tag.size() > 0) chk("drain_timeout", 1, 0);
   endtask

   task automatic until_idle(input int max);
      int n;
      n = 0;
      while (st != 0 && n < max) begin
         step();
         n++;
      end
      if (st != 0) chk("idle_timeout", 1, 0);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic offer(input logic [TAG_W-1:0] tag, input logic [63:0] data);
      s_valid = 1'b1;
      s_tag   = tag;
      s_data  = data;
      s_mode  = 1'($urandom);
   endtask

   initial begin
      int t_acc, a0, d0, n;
      rst = 1'b0; start = 0; flush = 0; s_valid = 0; s_mode = 0; s_data = '0; s_tag = '0;
      m_ready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_m_tag", m_tag, 0);
      chk("rst_s_ready", s_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_flush_done", flush_done, 0);
      @(negedge clk);
      rst = 1'b1;
      flush = 1'b1;  // ignored in IDLE
      step();
      flush = 1'b0;
      step();

      // Single block, latency check.
      pulse_start();
      start = 1'b1;  // ignored in RUN
      offer(4'd3, 64'h0123_4567_89AB_CDEF);
      t_acc = cyc;
      step();
      start = 1'b0;
      s_valid = 1'b0;
      n = 0;
      while (n < 40) begin
         #1;
         if (m_valid) break;
         step();
         n++;
      end
      chk("latency", 64'(cyc - t_acc), 64'(LATENCY + 1));
      chk("first_tag", m_tag, 4'd3);
      chk("first_data", m_data, xf(64'h0123_4567_89AB_CDEF));
      drain(10);

      // 20 back-to-back blocks.
      for (int i = 0; i < 20; i++) begin
         offer(TAG_W'(i % 16), {$urandom, $urandom});
         step();
      end
      drain(60);

      // Backpressure: only OUT_DEPTH admitted, then admission resumes after pops.
      m_ready = 1'b0;
      a0 = n_acc;
      for (int i = 0; i < 10; i++) begin
         offer(TAG_W'($urandom), {$urandom, $urandom});
         step();
      end
      chk("bp_accepted", 64'(n_acc - a0), 64'(OUT_DEPTH));
      m_ready = 1'b1;
      for (int i = 0; i < 30; i++) begin
         offer(TAG_W'($urandom), {$urandom, $urandom});
         step();
      end
      chk("bp_resumed", 64'(n_acc - a0 > int'(OUT_DEPTH)), 1);
      drain(60);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         s_valid = ($urandom_range(0, 9) < 7);
         s_tag   = TAG_W'($urandom);
         s_data  = {$urandom, $urandom};
         s_mode  = 1'($urandom);
         m_ready = ($urandom_range(0, 9) < 6);
         step();
      end
      drain(80);

      // Flush with 3 blocks in flight.
      for (int i = 0; i < 3; i++) begin
         offer(TAG_W'(i + 8), {$urandom, $urandom});
         step();
      end
      s_valid = 1'b0;
      flush = 1'b1;
      step();
      flush = 1'b0;
      offer(4'd1, 64'h1);  // must not be admitted while draining
      step();
      s_valid = 1'b0;
      d0 = n_done;
      until_idle(60);
      chk("flush_done_once", 64'(n_done - d0), 1);
      chk("flush_last_tag", 64'(last_tag), 64'd10);

      // Reset while 2 blocks in flight and 2 in the FIFO.
      pulse_start();
      m_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         offer(TAG_W'(i), {$urandom, $urandom});
         step();
      end
      s_valid = 1'b0;
      repeat (int'(LATENCY) + 2) step();
      for (int i = 0; i < 2; i++) begin
         offer(TAG_W'(i + 4), {$urandom, $urandom});
         step();
      end
      s_valid = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      #1;
      chk("midrst_m_valid", m_valid, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_s_ready", s_ready, 0);
      q_data.delete(); q_tag.delete(); q_arr.delete();
      st = 0;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      rst = 1'b1;
      m_ready = 1'b1;
      repeat (30) step();
      pulse_start();
      offer(4'd5, 64'hFEED_FACE_CAFE_BEEF);
      t_acc = cyc;
      step();
      s_valid = 1'b0;
      n = 0;
      while (n < 40) begin
         #1;
         if (m_valid) break;
         step();
         n++;
      end
      chk("post_rst_latency", 64'(cyc - t_acc), 64'(LATENCY + 1));
      chk("post_rst_tag", m_tag, 4'd5);
      drain(10);

      // Flush coincident with an accept.
      offer(4'd7, {$urandom, $urandom});
      flush = 1'b1;
      step();
      flush = 1'b0;
      s_valid = 1'b0;
      d0 = n_done;
      until_idle(60);
      chk("coinc_done", 64'(n_done - d0), 1);
      chk("coinc_tag", 64'(last_tag), 64'd7);
      repeat (3) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
